cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Coprocessor-0 register file and exception/interrupt resolver for the five-stage MIPS pipeline. Collects per-instruction exception flags from the Memory stage, prioritises them, commits architectural CP0 state (Status, Cause, EPC, BadVAddr, Count, Compare), and produces the `excepttype` word that the hazard unit uses to flush every stage, together with the redirect PC. It also serves `mfc0` reads from Execute and `mtc0` writes from Write-back.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hBFC0_0380: general exception entry PC.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `int_i` in 6: hardware interrupt lines, level-sensitive.
- `weW_i` in 1: `mtc0` write enable (Write-back).
- `waddrW_i` in 5: CP0 register number to write.
- `wdataW_i` in 32: write data.
- `raddrE_i` in 5: CP0 register number for `mfc0` (Execute).
- `rdataE_o` out 32: combinational read data.
- `pcM_i` in 32: Memory-stage PC.
- `in_delayslotM_i` in 1: Memory-stage instruction is in a branch delay slot.
- `syscallM_i`, `breakM_i`, `eretM_i`, `invalidM_i`, `overflowM_i`, `adelM_i`, `adesM_i` in 1 each: exception flags. `adelM_i` covers data loads only.
- `badaddrM_i` in 32: faulting data address.
- `excepttypeM_o` out 32: resolved exception code; zero means none.
- `newpc_o` out 32: redirect target, valid when `excepttypeM_o != 0`.
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o` out 32 each: register contents.
- `timer_int_o` out 1: timer interrupt pending.

## Operation
- Register numbers:
  - BadVAddr = 8, Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14.
  - Other addresses read 0; writes to them are ignored.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]. BEV[22] is read-only 1.
  - Cause: IP[9:8] (software interrupts) only.
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr: not writable by software.
- Cause.IP[15:10] = `{timer_int_o | int_i[5], int_i[4:0]}`, sampled every cycle.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Exception priority, highest first. Encoding in `excepttypeM_o`:
  - interrupt 32'h1
  - PC misaligned, `pcM_i[1:0] != 0`: 32'h4, BadVAddr ← `pcM_i`
  - invalid 32'hA
  - syscall 32'h8
  - break 32'h9
  - overflow 32'hC
  - AdEL data 32'h4, BadVAddr ← `badaddrM_i`
  - AdES 32'h5, BadVAddr ← `badaddrM_i`
  - eret 32'hE
- On a non-eret exception, at the commit edge:
  - EPC ← delay slot ? `pcM_i - 4` : `pcM_i`.
  - Cause.BD ← `in_delayslotM_i`.
  - Cause.ExcCode[6:2]: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - Status.EXL ← 1.
  - BadVAddr is updated only for address exceptions.
- On eret: Status.EXL ← 0.
- `newpc_o`:
  - eret: current EPC. If the same cycle has `weW_i` to EPC, use `wdataW_i` instead.
  - Any other exception: `EXC_VECTOR`.
- Count:
  - Increments every second cycle via an internal toggle bit.
  - A software write to Count loads the value and clears the toggle.
- Timer:
  - `timer_int_o` sets when Count == Compare and Compare != 0.
  - It stays set until Compare is written.
- `rdataE_o`:
  - Returns current register contents.
  - If the same cycle has `weW_i` to the same address, it bypasses the written value (merged with the read-only fields).

## Timing
- Exception detection and `newpc_o` are combinational from the M inputs. State update happens on the same rising edge at which the hazard unit flushes.
- All register writes take effect at the next rising edge.
- Reset values:
  - Status = 32'h0040_0000.
  - Cause, EPC, BadVAddr, Count, Compare, toggle = 0.
  - `timer_int_o` = 0.
  - `excepttypeM_o` = 0 while M flags are low.
- If `rst` is high on an edge, reset wins over any exception or write in that cycle.
- Simultaneous `mtc0` (W, the older instruction) and an exception (M):
  - The `mtc0` write applies first.
  - The exception then overrides the fields it touches: EXL, BD, ExcCode, EPC, BadVAddr.
- A write to Count in the same cycle as an increment: the write wins.
- A write to Compare in the same cycle as a Count match: the interrupt clears.
- Count wraps from 32'hFFFF_FFFF to 0.

## Structure
- Package `cp0_pkg` holds:
  - CP0 register address constants.
  - `excepttype` encodings and ExcCode values.
  - Status/Cause bit-position constants.
  - The Status reset value.
- Sub-module `cp0_exc_prio` is the combinational priority encoder. It takes the flags, interrupt-pending and PC alignment, and outputs `excepttype`, ExcCode and the BadVAddr-select signal.
- The top level holds all registers, Count/timer logic and the read mux.

## Test plan
- Reset, then read addresses 12/13/14 → 32'h0040_0000, 0, 0. Read address 3 → 0.
- `syscallM_i`=1, `pcM_i`=32'h8000_0100, not delay slot:
  - `excepttypeM_o`=8, `newpc_o`=32'hBFC0_0380.
  - Next cycle: EPC=32'h8000_0100, Cause.ExcCode=8, EXL=1.
- `overflowM_i` and `invalidM_i` together, in delay slot, `pcM_i`=32'h200:
  - `excepttypeM_o`=32'hA.
  - EPC=32'h1FC, Cause.BD=1.
- Status=32'h0040_8001 and Compare=10; Count reaches 10:
  - `timer_int_o`=1 and `excepttypeM_o`=1.
  - Writing Compare clears `timer_int_o`.
- `mtc0` EPC=32'h1234 in W with `eretM_i` in the same cycle:
  - `newpc_o`=32'h1234.
  - Next cycle: EXL=0 and EPC=32'h1234.
- `adesM_i` with `badaddrM_i`=32'h3 → `excepttypeM_o`=5, BadVAddr=3.
- Raise `rst` in the same cycle → all registers are at their reset values.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, excepttype/ExcCode encodings,
// Status/Cause field positions and the Status reset value.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef enum logic [1:0] {
        BADV_NONE,
        BADV_PC,
        BADV_DATA
    } badv_sel_e;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Pipeline-side bundle of the CP0 unit: mtc0/mfc0 ports, Memory-stage
// exception flags and the resolved exception/redirect plus register views.
interface cp0_exception_unit_if;

    logic [5:0]  int_i;
    logic        weW_i;
    logic [4:0]  waddrW_i;
    logic [31:0] wdataW_i;
    logic [4:0]  raddrE_i;
    logic [31:0] rdataE_o;
    logic [31:0] pcM_i;
    logic        in_delayslotM_i;
    logic        syscallM_i;
    logic        breakM_i;
    logic        eretM_i;
    logic        invalidM_i;
    logic        overflowM_i;
    logic        adelM_i;
    logic        adesM_i;
    logic [31:0] badaddrM_i;
    logic [31:0] excepttypeM_o;
    logic [31:0] newpc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    modport slave (
        input  int_i, weW_i, waddrW_i, wdataW_i, raddrE_i, pcM_i, in_delayslotM_i,
               syscallM_i, breakM_i, eretM_i, invalidM_i, overflowM_i, adelM_i,
               adesM_i, badaddrM_i,
        output rdataE_o, excepttypeM_o, newpc_o, status_o, cause_o, epc_o,
               badvaddr_o, count_o, compare_o, timer_int_o
    );

    modport master (
        output int_i, weW_i, waddrW_i, wdataW_i, raddrE_i, pcM_i, in_delayslotM_i,
               syscallM_i, breakM_i, eretM_i, invalidM_i, overflowM_i, adelM_i,
               adesM_i, badaddrM_i,
        input  rdataE_o, excepttypeM_o, newpc_o, status_o, cause_o, epc_o,
               badvaddr_o, count_o, compare_o, timer_int_o
    );

endinterface

// File: rtl/cp0_exc_prio.sv
// Combinational exception priority encoder: picks the highest-priority cause
// and reports its excepttype word, ExcCode and which address feeds BadVAddr.
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic        int_pending_i,
    input  logic        pc_misaligned_i,
    input  logic        invalid_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        overflow_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    output logic [31:0] excepttype_o,
    output logic [4:0]  exccode_o,
    output badv_sel_e   badv_sel_o
);

    always_comb begin
        excepttype_o = '0;
        exccode_o    = CODE_INT;
        badv_sel_o   = BADV_NONE;
        if (int_pending_i) begin
            excepttype_o = EXC_INT;
            exccode_o    = CODE_INT;
        end else if (pc_misaligned_i) begin
            excepttype_o = EXC_ADEL;
            exccode_o    = CODE_ADEL;
            badv_sel_o   = BADV_PC;
        end else if (invalid_i) begin
            excepttype_o = EXC_RI;
            exccode_o    = CODE_RI;
        end else if (syscall_i) begin
            excepttype_o = EXC_SYS;
            exccode_o    = CODE_SYS;
        end else if (break_i) begin
            excepttype_o = EXC_BP;
            exccode_o    = CODE_BP;
        end else if (overflow_i) begin
            excepttype_o = EXC_OV;
            exccode_o    = CODE_OV;
        end else if (adel_i) begin
            excepttype_o = EXC_ADEL;
            exccode_o    = CODE_ADEL;
            badv_sel_o   = BADV_DATA;
        end else if (ades_i) begin
            excepttype_o = EXC_ADES;
            exccode_o    = CODE_ADES;
            badv_sel_o   = BADV_DATA;
        end else if (eret_i) begin
            excepttype_o = EXC_ERET;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file: commits exceptions chosen by cp0_exc_prio, runs the
// Count/Compare timer and serves mfc0 reads with mtc0 write-back bypass.
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                 clk,
    input  logic                 rst,
    cp0_exception_unit_if.slave  bus
);

    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
    logic        toggle_q, toggle_d, timer_q, timer_d;
    logic [31:0] status_w, cause_w, epc_w, count_w, compare_w;
    logic        count_wr, compare_wr, int_pending;
    logic [31:0] excepttype;
    logic [4:0]  exccode;
    badv_sel_e   badv_sel;

    assign count_wr    = bus.weW_i && (bus.waddrW_i == CP0_COUNT);
    assign compare_wr  = bus.weW_i && (bus.waddrW_i == CP0_COMPARE);
    assign int_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                         & (|(cause_q[15:8] & status_q[15:8]));

    // Register contents with only this cycle's mtc0 applied; feeds the read bypass and eret target.
    always_comb begin
        status_w  = status_q;
        cause_w   = cause_q;
        epc_w     = epc_q;
        count_w   = count_q;
        compare_w = compare_q;
        if (bus.weW_i) begin
            case (bus.waddrW_i)
                CP0_STATUS: begin
                    status_w             = bus.wdataW_i & STATUS_WMASK;
                    status_w[STATUS_BEV] = 1'b1;
                end
                CP0_CAUSE:   cause_w   = (cause_q & ~CAUSE_WMASK) | (bus.wdataW_i & CAUSE_WMASK);
                CP0_EPC:     epc_w     = bus.wdataW_i;
                CP0_COUNT:   count_w   = bus.wdataW_i;
                CP0_COMPARE: compare_w = bus.wdataW_i;
                default: ;
            endcase
        end
    end

    cp0_exc_prio u_prio (
        .int_pending_i   (int_pending),
        .pc_misaligned_i (|bus.pcM_i[1:0]),
        .invalid_i       (bus.invalidM_i),
        .syscall_i       (bus.syscallM_i),
        .break_i         (bus.breakM_i),
        .overflow_i      (bus.overflowM_i),
        .adel_i          (bus.adelM_i),
        .ades_i          (bus.adesM_i),
        .eret_i          (bus.eretM_i),
        .excepttype_o    (excepttype),
        .exccode_o       (exccode),
        .badv_sel_o      (badv_sel)
    );

    always_comb begin
        case (bus.raddrE_i)
            CP0_BADVADDR: bus.rdataE_o = badvaddr_q;
            CP0_COUNT:    bus.rdataE_o = count_w;
            CP0_COMPARE:  bus.rdataE_o = compare_w;
            CP0_STATUS:   bus.rdataE_o = status_w;
            CP0_CAUSE:    bus.rdataE_o = cause_w;
            CP0_EPC:      bus.rdataE_o = epc_w;
            default:      bus.rdataE_o = '0;
        endcase
    end

    // The mtc0 result is the base; a committing exception then overrides its own fields.
    always_comb begin
        status_d   = status_w;
        cause_d    = cause_w;
        epc_d      = epc_w;
        compare_d  = compare_w;
        badvaddr_d = badvaddr_q;
        count_d    = count_wr ? bus.wdataW_i : count_q + {31'd0, toggle_q};
        toggle_d   = count_wr ? 1'b0 : ~toggle_q;
        timer_d    = compare_wr ? 1'b0
                                : (timer_q | ((count_q == compare_q) && (compare_q != '0)));
        cause_d[15:10] = {timer_q | bus.int_i[5], bus.int_i[4:0]};
        if (excepttype == EXC_ERET) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (excepttype != '0) begin
            status_d[STATUS_EXL] = 1'b1;
            cause_d[CAUSE_BD]    = bus.in_delayslotM_i;
            cause_d[6:2]         = exccode;
            epc_d                = bus.in_delayslotM_i ? bus.pcM_i - 32'd4 : bus.pcM_i;
            case (badv_sel)
                BADV_PC:   badvaddr_d = bus.pcM_i;
                BADV_DATA: badvaddr_d = bus.badaddrM_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            toggle_q   <= 1'b0;
            timer_q    <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            toggle_q   <= toggle_d;
            timer_q    <= timer_d;
        end
    end

    assign bus.excepttypeM_o = excepttype;
    assign bus.newpc_o       = (excepttype == EXC_ERET) ? epc_w : EXC_VECTOR;
    assign bus.status_o      = status_q;
    assign bus.cause_o       = cause_q;
    assign bus.epc_o         = epc_q;
    assign bus.badvaddr_o    = badvaddr_q;
    assign bus.count_o       = count_q;
    assign bus.compare_o     = compare_q;
    assign bus.timer_int_o   = timer_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: a cycle model predicts every output,
// a negedge monitor compares, with directed scenarios followed by random traffic.
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cp0_exception_unit_if bus();

    cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  intr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] pc;
        logic        ds;
        logic        sys, brk, eret, inv, ovf, adel, ades;
        logic [31:0] badaddr;
    } stim_t;

    typedef struct {
        logic [31:0] exctype, newpc, rdata;
        logic [31:0] status, cause, epc, badv, count, compare;
        logic        timer;
    } exp_t;

    exp_t  expQ[$];
    int    vectors = 0;
    int    miscompares = 0;
    stim_t curStim;

    logic [31:0] mStatus, mCause, mEpc, mBadv, mCount, mCompare;
    logic        mToggle, mTimer;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mStatus = 32'h0040_0000; mCause = '0; mEpc = '0; mBadv = '0;
        mCount = '0; mCompare = '0; mToggle = 1'b0; mTimer = 1'b0;
    endfunction

    // Architectural value of a register once this cycle's mtc0 (and nothing else) is applied.
    function automatic logic [31:0] regAfterWrite(input stim_t s, input logic [4:0] addr);
        logic [31:0] v;
        case (addr)
            5'd8:  v = mBadv;
            5'd9:  v = mCount;
            5'd11: v = mCompare;
            5'd12: v = mStatus;
            5'd13: v = mCause;
            5'd14: v = mEpc;
            default: v = '0;
        endcase
        if (s.we && s.waddr == addr) begin
            case (addr)
                5'd9, 5'd11, 5'd14: v = s.wdata;
                5'd12: v = (s.wdata & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: v = (mCause & ~32'h0000_0300) | (s.wdata & 32'h0000_0300);
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic void resolve(input stim_t s, output logic [31:0] et,
                                    output logic [4:0] code, output int bsel);
        logic pend;
        pend = mStatus[0] && !mStatus[1] && ((mCause[15:8] & mStatus[15:8]) != 8'h00);
        et = '0; code = '0; bsel = 0;
        if (pend)                 begin et = 32'h1; code = 5'd0; end
        else if (s.pc[1:0] != 0)  begin et = 32'h4; code = 5'd4; bsel = 1; end
        else if (s.inv)           begin et = 32'hA; code = 5'd10; end
        else if (s.sys)           begin et = 32'h8; code = 5'd8; end
        else if (s.brk)           begin et = 32'h9; code = 5'd9; end
        else if (s.ovf)           begin et = 32'hC; code = 5'd12; end
        else if (s.adel)          begin et = 32'h4; code = 5'd4; bsel = 2; end
        else if (s.ades)          begin et = 32'h5; code = 5'd5; bsel = 2; end
        else if (s.eret)          begin et = 32'hE; end
    endfunction

    function automatic void modelUpdate(input stim_t s);
        logic [31:0] et, nStatus, nCause, nEpc, nBadv, nCount, nCompare;
        logic [4:0]  code;
        logic        nToggle, nTimer;
        int          bsel;
        if (s.rst) begin
            modelReset();
            return;
        end
        resolve(s, et, code, bsel);
        nStatus  = regAfterWrite(s, 5'd12);
        nCause   = regAfterWrite(s, 5'd13);
        nEpc     = regAfterWrite(s, 5'd14);
        nCompare = regAfterWrite(s, 5'd11);
        nBadv    = mBadv;
        if (s.we && s.waddr == 5'd9) begin
            nCount = s.wdata; nToggle = 1'b0;
        end else begin
            nCount = mToggle ? mCount + 32'd1 : mCount; nToggle = !mToggle;
        end
        if (s.we && s.waddr == 5'd11) nTimer = 1'b0;
        else nTimer = mTimer || (mCount == mCompare && mCompare != 0);
        nCause[15:10] = {mTimer | s.intr[5], s.intr[4:0]};
        if (et == 32'hE) begin
            nStatus[1] = 1'b0;
        end else if (et != 0) begin
            nStatus[1]  = 1'b1;
            nCause[31]  = s.ds;
            nCause[6:2] = code;
            nEpc        = s.ds ? s.pc - 32'd4 : s.pc;
            if (bsel == 1) nBadv = s.pc;
            else if (bsel == 2) nBadv = s.badaddr;
        end
        mStatus = nStatus; mCause = nCause; mEpc = nEpc; mBadv = nBadv;
        mCount = nCount; mCompare = nCompare; mToggle = nToggle; mTimer = nTimer;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.intr = '0; s.we = 0; s.waddr = '0; s.wdata = '0; s.raddr = '0;
        s.pc = 32'h0000_1000; s.ds = 0; s.sys = 0; s.brk = 0; s.eret = 0; s.inv = 0;
        s.ovf = 0; s.adel = 0; s.ades = 0; s.badaddr = '0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] a, input logic [31:0] d);
        stim_t s = idle();
        s.we = 1; s.waddr = a; s.wdata = d;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s = idle();
        logic [4:0] addrs [8];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
        s.rst   = ($urandom_range(0, 63) == 0);
        s.intr  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
        s.we    = ($urandom_range(0, 2) == 0);
        s.waddr = addrs[$urandom_range(0, 7)];
        s.wdata = (s.waddr == 5'd11) ? mCount + 32'($urandom_range(1, 24)) : $urandom;
        s.raddr = ($urandom_range(0, 3) == 0) ? s.waddr : addrs[$urandom_range(0, 7)];
        s.pc    = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ~32'h3);
        s.ds    = 1'($urandom);
        s.sys   = ($urandom_range(0, 11) == 0);
        s.brk   = ($urandom_range(0, 11) == 0);
        s.eret  = ($urandom_range(0, 11) == 0);
        s.inv   = ($urandom_range(0, 11) == 0);
        s.ovf   = ($urandom_range(0, 11) == 0);
        s.adel  = ($urandom_range(0, 11) == 0);
        s.ades  = ($urandom_range(0, 11) == 0);
        s.badaddr = $urandom;
        return s;
    endfunction

    // Drive one cycle's inputs and queue what the DUT must show during that cycle.
    task automatic applyStimulus(input stim_t s);
        exp_t        e;
        logic [31:0] et;
        logic [4:0]  code;
        int          bsel;
        rst = s.rst;
        bus.int_i = s.intr; bus.weW_i = s.we; bus.waddrW_i = s.waddr; bus.wdataW_i = s.wdata;
        bus.raddrE_i = s.raddr; bus.pcM_i = s.pc; bus.in_delayslotM_i = s.ds;
        bus.syscallM_i = s.sys; bus.breakM_i = s.brk; bus.eretM_i = s.eret;
        bus.invalidM_i = s.inv; bus.overflowM_i = s.ovf; bus.adelM_i = s.adel;
        bus.adesM_i = s.ades; bus.badaddrM_i = s.badaddr;
        resolve(s, et, code, bsel);
        e.exctype = et;
        e.newpc   = (et == 32'hE) ? regAfterWrite(s, 5'd14) : VEC;
        e.rdata   = regAfterWrite(s, s.raddr);
        e.status  = mStatus; e.cause = mCause; e.epc = mEpc; e.badv = mBadv;
        e.count   = mCount; e.compare = mCompare; e.timer = mTimer;
        expQ.push_back(e);
        curStim = s;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate(curStim);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("excepttype", bus.excepttypeM_o, e.exctype);
        if (e.exctype != 0) cmp("newpc", bus.newpc_o, e.newpc);
        cmp("rdataE", bus.rdataE_o, e.rdata);
        cmp("status", bus.status_o, e.status);
        cmp("cause", bus.cause_o, e.cause);
        cmp("epc", bus.epc_o, e.epc);
        cmp("badvaddr", bus.badvaddr_o, e.badv);
        cmp("count", bus.count_o, e.count);
        cmp("compare", bus.compare_o, e.compare);
        cmp("timer_int", {31'd0, bus.timer_int_o}, {31'd0, e.timer});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    task automatic readCheck(input logic [4:0] a, input logic [31:0] exp);
        stim_t s = idle();
        s.raddr = a;
        applyStimulus(s);
        #1;
        cmp($sformatf("read reg %0d", a), bus.rdataE_o, exp);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        int    found;
        modelReset();
        s = idle();
        s.rst = 1;
        applyStimulus(s);
        expQ.delete();
        @(posedge clk);
        #1;
        applyStimulus(s);
        tick();

        readCheck(5'd12, 32'h0040_0000);
        readCheck(5'd13, 32'h0);
        readCheck(5'd14, 32'h0);
        readCheck(5'd3, 32'h0);

        s = idle(); s.sys = 1; s.pc = 32'h8000_0100;
        applyStimulus(s);
        #1;
        cmp("syscall excepttype", bus.excepttypeM_o, 32'h8);
        cmp("syscall newpc", bus.newpc_o, VEC);
        tick();
        cmp("syscall EPC", bus.epc_o, 32'h8000_0100);
        cmp("syscall ExcCode", {27'd0, bus.cause_o[6:2]}, 32'd8);
        cmp("syscall EXL", {31'd0, bus.status_o[1]}, 32'd1);

        s = idle(); s.ovf = 1; s.inv = 1; s.ds = 1; s.pc = 32'h0000_0200;
        applyStimulus(s);
        #1;
        cmp("ri-over-ov excepttype", bus.excepttypeM_o, 32'hA);
        tick();
        cmp("delay-slot EPC", bus.epc_o, 32'h0000_01FC);
        cmp("delay-slot BD", {31'd0, bus.cause_o[31]}, 32'd1);

        applyStimulus(wr(5'd12, 32'h0040_8001)); tick();
        applyStimulus(wr(5'd11, 32'd10));        tick();
        applyStimulus(wr(5'd9, 32'd0));          tick();
        found = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(idle());
            #1;
            if (bus.excepttypeM_o == 32'h1) begin
                found = 1;
                break;
            end
            tick();
        end
        cmp("timer interrupt seen", found, 1);
        if (found == 1) begin
            cmp("timer_int set", {31'd0, bus.timer_int_o}, 32'd1);
            tick();
        end
        applyStimulus(wr(5'd11, 32'd0));
        tick();
        cmp("timer_int cleared", {31'd0, bus.timer_int_o}, 32'd0);

        s = wr(5'd14, 32'h0000_1234); s.eret = 1;
        applyStimulus(s);
        #1;
        cmp("eret bypass newpc", bus.newpc_o, 32'h0000_1234);
        tick();
        cmp("eret EXL", {31'd0, bus.status_o[1]}, 32'd0);
        cmp("eret EPC", bus.epc_o, 32'h0000_1234);

        s = idle(); s.ades = 1; s.badaddr = 32'h3;
        applyStimulus(s);
        #1;
        cmp("ades excepttype", bus.excepttypeM_o, 32'h5);
        tick();
        cmp("ades BadVAddr", bus.badvaddr_o, 32'h3);

        s = wr(5'd14, 32'hDEAD_BEEF); s.rst = 1; s.sys = 1;
        applyStimulus(s);
        tick();
        cmp("reset status", bus.status_o, 32'h0040_0000);
        cmp("reset cause", bus.cause_o, 32'h0);
        cmp("reset epc", bus.epc_o, 32'h0);
        cmp("reset badvaddr", bus.badvaddr_o, 32'h0);
        cmp("reset count", bus.count_o, 32'h0);

        for (int i = 0; i < 500; i++) begin
            applyStimulus(randStim());
            tick();
        end
        applyStimulus(idle());
        tick();

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        cmp("scoreboard drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
